// File: rtl/life_manager_pkg.sv
// -----------------------------------------------------------------------------
// life_manager_pkg
// Shared game package for the life/health block.
// Contents:
//   life_state_e         - life FSM state encoding
//   DEF_START_LIFE       - default life count loaded on a new game
//   DEF_MAX_LIFE         - default life ceiling (must stay <= 7, currLife is 3 bits)
//   LIFE_ICON_*          - display constants for the life-icon row
//   life_sat_inc()       - saturating increment of a 3-bit life count
// -----------------------------------------------------------------------------
package life_manager_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALIVE     = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } life_state_e;

  localparam int DEF_START_LIFE = 3;
  localparam int DEF_MAX_LIFE   = 5;

  // Life-icon row geometry used by the display that consumes currLife.
  localparam int LIFE_ICON_WIDTH  = 16;
  localparam int LIFE_ICON_HEIGHT = 16;
  localparam int LIFE_ICON_GAP    = 4;
  localparam int LIFE_ICON_X0     = 8;
  localparam int LIFE_ICON_Y0     = 8;

  // Increment a life count without exceeding max_life.
  function automatic logic [2:0] life_sat_inc(input logic [2:0] life,
                                              input logic [2:0] max_life);
    logic [2:0] res;
    if (life >= max_life) begin
      res = max_life;
    end else begin
      res = life + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/life_manager_frame_timer.sv
// -----------------------------------------------------------------------------
// life_manager_frame_timer
// Loadable down-counter advanced by the per-frame pulse; provides the
// invulnerability frame count for life_manager.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset (counter -> 0)
//   clear    in   synchronous clear (highest priority after reset)
//   load     in   load load_val into the counter
//   load_val in   value to load
//   tick     in   startOfFrame pulse; decrements the counter, stops at 0
//   done     out  counter currently holds 1, i.e. the next tick expires it
// -----------------------------------------------------------------------------
module life_manager_frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next counter value: clear, then load, then a non-wrapping decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != {WIDTH{1'b0}})) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/life_manager.sv
// -----------------------------------------------------------------------------
// life_manager
// Player life bookkeeping: life count, hit handling with a post-hit
// invulnerability window (icons blink while invulnerable), extra lives and
// game over.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   startOfFrame  in   one-clk pulse per video frame
//   newGame       in   one-clk pulse, starts/restarts a game
//   hitReq        in   one-clk pulse, player hit
//   bonusReq      in   one-clk pulse, extra life collected
//   currLife      out  current life count (registered)
//   lifeVisible   out  life-icon draw gate (registered)
//   invulnerable  out  high while in INVULN (registered)
//   gameOver      out  high while in GAME_OVER (registered)
//   lifeLost      out  one-clk pulse per accepted hit (registered)
// -----------------------------------------------------------------------------
module life_manager
  import life_manager_pkg::*;
#(
  parameter int START_LIFE    = DEF_START_LIFE,
  parameter int MAX_LIFE      = DEF_MAX_LIFE,   // must be <= 7
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       newGame,
  input  logic       hitReq,
  input  logic       bonusReq,
  output logic [2:0] currLife,
  output logic       lifeVisible,
  output logic       invulnerable,
  output logic       gameOver,
  output logic       lifeLost
);

  localparam int TW = $clog2(INVULN_FRAMES) + 1;
  localparam int BW = $clog2(BLINK_FRAMES) + 1;

  localparam logic [2:0]    MAX_L      = 3'(MAX_LIFE);
  // A start value above the ceiling is clamped so currLife never exceeds it.
  localparam logic [2:0]    START_L    = (START_LIFE > MAX_LIFE) ? 3'(MAX_LIFE) : 3'(START_LIFE);
  localparam logic [TW-1:0] INVULN_VAL = TW'(INVULN_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  life_state_e   state_d, state_q;
  logic [2:0]    life_d, life_q;
  logic          vis_d, vis_q;
  logic          inv_d, inv_q;
  logic          go_d, go_q;
  logic          lost_d, lost_q;
  logic [BW-1:0] blink_d, blink_q;

  logic          timer_clear_s;
  logic          timer_load_s;
  logic          timer_done_s;

  life_manager_frame_timer #(
    .WIDTH(TW)
  ) u_frame_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear_s),
    .load     (timer_load_s),
    .load_val (INVULN_VAL),
    .tick     (startOfFrame),
    .done     (timer_done_s)
  );

  // Next-state and next-output computation for the life FSM.
  always_comb begin
    state_d       = state_q;
    life_d        = life_q;
    vis_d         = vis_q;
    lost_d        = 1'b0;
    blink_d       = blink_q;
    timer_clear_s = 1'b0;
    timer_load_s  = 1'b0;

    if (newGame) begin
      // newGame wins over hit/bonus arriving in the same cycle.
      state_d       = ALIVE;
      life_d        = START_L;
      vis_d         = 1'b1;
      blink_d       = {BW{1'b0}};
      timer_clear_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          life_d = 3'd0;
          vis_d  = 1'b1;
        end

        ALIVE: begin
          if (hitReq) begin
            // Hit takes precedence; a simultaneous bonus is dropped.
            lost_d = 1'b1;
            if (life_q > 3'd1) begin
              state_d      = INVULN;
              life_d       = life_q - 3'd1;
              vis_d        = 1'b0;
              blink_d      = {BW{1'b0}};
              timer_load_s = 1'b1;
            end else begin
              state_d = GAME_OVER;
              life_d  = 3'd0;
              vis_d   = 1'b1;
            end
          end else if (bonusReq) begin
            life_d = life_sat_inc(life_q, MAX_L);
          end else begin
            life_d = life_q;
          end
        end

        INVULN: begin
          if (bonusReq) begin
            life_d = life_sat_inc(life_q, MAX_L);
          end else begin
            life_d = life_q;
          end
          if (startOfFrame) begin
            if (timer_done_s) begin
              state_d = ALIVE;
              vis_d   = 1'b1;
              blink_d = {BW{1'b0}};
            end else if (blink_q == BLINK_LAST) begin
              blink_d = {BW{1'b0}};
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q + BW'(1);
            end
          end else begin
            blink_d = blink_q;
          end
        end

        GAME_OVER: begin
          life_d = 3'd0;
          vis_d  = 1'b1;
        end

        default: begin
          state_d = IDLE;
          life_d  = 3'd0;
          vis_d   = 1'b1;
          blink_d = {BW{1'b0}};
        end
      endcase
    end

    inv_d = (state_d == INVULN);
    go_d  = (state_d == GAME_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      life_q  <= 3'd0;
      vis_q   <= 1'b1;
      inv_q   <= 1'b0;
      go_q    <= 1'b0;
      lost_q  <= 1'b0;
      blink_q <= {BW{1'b0}};
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
      vis_q   <= vis_d;
      inv_q   <= inv_d;
      go_q    <= go_d;
      lost_q  <= lost_d;
      blink_q <= blink_d;
    end
  end

  assign currLife     = life_q;
  assign lifeVisible  = vis_q;
  assign invulnerable = inv_q;
  assign gameOver     = go_q;
  assign lifeLost     = lost_q;

endmodule

// File: tb/tb_life_manager.sv
// -----------------------------------------------------------------------------
// tb_life_manager
// Directed self-checking bench for life_manager with default parameters
// (START_LIFE=3, MAX_LIFE=5, INVULN_FRAMES=90, BLINK_FRAMES=8).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. after the edge that consumed the previous inputs.
// -----------------------------------------------------------------------------
module tb_life_manager;

  logic       clk;
  logic       reset;
  logic       sof;
  logic       new_game;
  logic       hit;
  logic       bonus;
  logic [2:0] curr_life;
  logic       life_visible;
  logic       invuln;
  logic       game_over;
  logic       life_lost;

  int vectors;
  int miscompares;

  life_manager dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof),
    .newGame      (new_game),
    .hitReq       (hit),
    .bonusReq     (bonus),
    .currLife     (curr_life),
    .lifeVisible  (life_visible),
    .invulnerable (invuln),
    .gameOver     (game_over),
    .lifeLost     (life_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One video frame: a startOfFrame cycle followed by a quiet cycle.
  task automatic frame();
    sof = 1'b1;
    step();
    sof = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame();
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  task automatic pulse_bonus();
    bonus = 1'b1;
    step();
    bonus = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    sof      = 1'b0;
    new_game = 1'b0;
    hit      = 1'b0;
    bonus    = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_life", curr_life, 0);
    chk("rst_vis", life_visible, 1);
    chk("rst_inv", invuln, 0);
    chk("rst_go", game_over, 0);
    chk("rst_lost", life_lost, 0);

    // IDLE ignores hit and bonus
    pulse_hit();
    chk("idle_hit_lost", life_lost, 0);
    chk("idle_hit_life", curr_life, 0);
    pulse_bonus();
    chk("idle_bonus_life", curr_life, 0);

    // New game
    pulse_new_game();
    chk("ng_life", curr_life, 3);
    chk("ng_vis", life_visible, 1);
    chk("ng_inv", invuln, 0);
    chk("ng_go", game_over, 0);

    // newGame beats a simultaneous hit
    new_game = 1'b1;
    hit      = 1'b1;
    step();
    new_game = 1'b0;
    hit      = 1'b0;
    chk("ngprio_life", curr_life, 3);
    chk("ngprio_lost", life_lost, 0);
    chk("ngprio_inv", invuln, 0);

    // Hit from 3 lives
    pulse_hit();
    chk("hit1_life", curr_life, 2);
    chk("hit1_lost", life_lost, 1);
    chk("hit1_inv", invuln, 1);
    chk("hit1_vis", life_visible, 0);
    step();
    chk("hit1_lost_end", life_lost, 0);

    // Invulnerability window with blink, second hit, and bonus
    for (int f = 1; f <= 89; f++) begin
      frame();
      if (f == 7)  chk("blink_f7", life_visible, 0);
      if (f == 8)  chk("blink_f8", life_visible, 1);
      if (f == 15) chk("blink_f15", life_visible, 1);
      if (f == 16) chk("blink_f16", life_visible, 0);
      if (f == 10) begin
        pulse_hit();
        chk("inv_hit_life", curr_life, 2);
        chk("inv_hit_lost", life_lost, 0);
      end
      if (f == 20) begin
        pulse_bonus();
        chk("inv_bonus_life", curr_life, 3);
        chk("inv_bonus_inv", invuln, 1);
      end
    end
    chk("f89_inv", invuln, 1);
    frame();
    chk("f90_inv", invuln, 0);
    chk("f90_vis", life_visible, 1);
    chk("f90_life", curr_life, 3);

    // Bonus saturation at 5
    pulse_bonus();
    chk("bonus4", curr_life, 4);
    pulse_bonus();
    chk("bonus5", curr_life, 5);
    pulse_bonus();
    chk("bonus_sat", curr_life, 5);

    // Get to 2 lives in ALIVE, then hit+bonus together
    pulse_new_game();
    pulse_hit();
    frames(90);
    chk("alive2_life", curr_life, 2);
    chk("alive2_inv", invuln, 0);
    hit   = 1'b1;
    bonus = 1'b1;
    step();
    hit   = 1'b0;
    bonus = 1'b0;
    chk("hitbonus_life", curr_life, 1);
    chk("hitbonus_inv", invuln, 1);
    chk("hitbonus_lost", life_lost, 1);

    // Last life lost -> game over
    frames(90);
    chk("alive1_inv", invuln, 0);
    pulse_hit();
    chk("go_life", curr_life, 0);
    chk("go_go", game_over, 1);
    chk("go_lost", life_lost, 1);
    chk("go_inv", invuln, 0);
    pulse_hit();
    chk("go_hit_lost", life_lost, 0);
    chk("go_hit_life", curr_life, 0);
    pulse_bonus();
    chk("go_bonus_life", curr_life, 0);
    chk("go_bonus_go", game_over, 1);
    chk("go_vis", life_visible, 1);
    pulse_new_game();
    chk("go_ng_life", curr_life, 3);
    chk("go_ng_go", game_over, 0);

    // Reset in the middle of invulnerability
    pulse_hit();
    frames(40);
    chk("pre_rst_inv", invuln, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_life", curr_life, 0);
    chk("midrst_inv", invuln, 0);
    chk("midrst_vis", life_visible, 1);
    chk("midrst_go", game_over, 0);
    pulse_hit();
    chk("midrst_hit_lost", life_lost, 0);
    chk("midrst_hit_life", curr_life, 0);

    // Reset beats newGame
    reset    = 1'b1;
    new_game = 1'b1;
    step();
    reset    = 1'b0;
    new_game = 1'b0;
    chk("rstprio_life", curr_life, 0);
    chk("rstprio_inv", invuln, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/life_manager.md
LIFE_MANAGER -- requirements
Module: life_manager

Interface
REQ-001 Parameter START_LIFE, default 3: life count loaded on new game.
REQ-002 Parameter MAX_LIFE, default 5: saturation ceiling for currLife; must be at most 7.
REQ-003 Parameter INVULN_FRAMES, default 90: frames of invulnerability after a non-fatal hit.
REQ-004 Parameter BLINK_FRAMES, default 8: frames per visibility half-period while invulnerable.
REQ-005 clk  input  1  system clock; the only clock in the block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 startOfFrame  input  1  one-clk pulse per video frame; the time base for all frame counters.
REQ-008 newGame  input  1  one-clk pulse that starts or restarts a game.
REQ-009 hitReq  input  1  one-clk pulse: the player was hit.
REQ-010 bonusReq  input  1  one-clk pulse: an extra life was collected.
REQ-011 currLife  output  3  current life count; drives the life-icon display.
REQ-012 lifeVisible  output  1  display gating; the display draw request is ANDed with this.
REQ-013 invulnerable  output  1  high while in INVULN.
REQ-014 gameOver  output  1  high while in GAME_OVER.
REQ-015 lifeLost  output  1  one-clk pulse for each accepted hit.

Function
REQ-016 FSM states: IDLE, ALIVE, INVULN, GAME_OVER. All outputs are registered and update one clk after the causing input.
REQ-017 IDLE: currLife=0, lifeVisible=1, and hitReq and bonusReq are ignored.
REQ-018 newGame in any state → ALIVE with currLife=START_LIFE, frame and blink counters cleared, lifeVisible=1; newGame has priority over all other inputs in the same cycle.
REQ-019 ALIVE + hitReq with currLife>1 → INVULN: currLife decrements by 1, invulnCnt=INVULN_FRAMES, blinkCnt=0, lifeLost=1 for one clk.
REQ-020 ALIVE + hitReq with currLife==1 → GAME_OVER: currLife=0, lifeLost=1 for one clk, gameOver=1.
REQ-021 hitReq in INVULN, GAME_OVER or IDLE is discarded and produces no lifeLost.
REQ-022 bonusReq in ALIVE or INVULN increments currLife, saturating at MAX_LIFE; the state is unchanged.
REQ-023 hitReq and bonusReq in the same cycle in ALIVE: the hit is processed and the bonus is discarded.
REQ-024 INVULN: on each startOfFrame, invulnCnt decrements; the startOfFrame that finds invulnCnt==1 → ALIVE with lifeVisible=1.
REQ-025 INVULN blink: blinkCnt counts startOfFrame pulses 0..BLINK_FRAMES-1, then wraps; lifeVisible toggles on each wrap and starts at 0 on entry to INVULN.
REQ-026 GAME_OVER: currLife=0 and lifeVisible=1, held until newGame; bonusReq is ignored.
REQ-027 Counter widths are sized by $clog2 of the parameter plus 1; no counter wraps except blinkCnt.
REQ-028 currLife never exceeds MAX_LIFE and never underflows below 0.

Reset
REQ-029 On reset: state=IDLE, currLife=0, lifeVisible=1, invulnerable=0, gameOver=0, lifeLost=0, all counters 0.
REQ-030 Reset asserted mid-INVULN or mid-blink aborts the sequence; the first cycle after reset deassertion behaves as IDLE.
REQ-031 Reset has priority over newGame.

Structure
REQ-032 The FSM state enum and the default START_LIFE and MAX_LIFE constants live in the shared game package, alongside the display icon constants.
REQ-033 One sub-module, frame_timer, implements the loadable down-counter clocked by startOfFrame with a done flag; it is used for invulnCnt.
REQ-034 Blink logic and the FSM stay in life_manager.

Verification
REQ-035 Reset, newGame → currLife=3, ALIVE, lifeVisible=1 one clk later.
REQ-036 currLife=3, hitReq → currLife=2, lifeLost pulse, invulnerable=1; 89 frames later invulnerable is still 1; at the 90th frame → ALIVE.
REQ-037 In INVULN, lifeVisible toggles 0→1 after 8 frames and 1→0 after 16; a second hitReq at frame 10 leaves currLife=2.
REQ-038 currLife=1, hitReq → currLife=0, gameOver=1; a later hitReq or bonusReq changes nothing; newGame → currLife=3, gameOver=0.
REQ-039 currLife=5, bonusReq → currLife stays 5; currLife=2 with hitReq and bonusReq in the same cycle → currLife=1, INVULN.
REQ-040 Reset asserted at INVULN frame 40 → IDLE, currLife=0, invulnerable=0, lifeVisible=1.
